// File: rtl/pattern_matcher_usb_pkg.sv
// Shared constants and types for the multi-channel USB byte-stream pattern matcher.
package pattern_matcher_usb_pkg;

  localparam int          BYTE_W             = 8;
  localparam logic        MODE_ANY           = 1'b0;
  localparam logic        MODE_SEQ           = 1'b1;
  localparam logic [15:0] NUM_TRIG_UNLIMITED = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/pattern_slot_compare.sv
// One pattern slot: masked compare of {history, current byte} against the slot
// pattern, plus the previous-hit flag used to edge-detect runs of hits.
module pattern_slot_compare
  import pattern_matcher_usb_pkg::*;
#(
  parameter int pPATTERN_BYTES = 8
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   clear_i,
  input  logic                                   step_i,
  input  logic [(pPATTERN_BYTES-1)*BYTE_W-1:0]   history_i,
  input  logic [BYTE_W-1:0]                      cur_byte_i,
  input  logic [pPATTERN_BYTES*BYTE_W-1:0]       pattern_i,
  input  logic [pPATTERN_BYTES*BYTE_W-1:0]       mask_i,
  input  logic [7:0]                             length_i,
  input  logic [7:0]                             byte_count_i,
  output logic                                   hit_o,
  output logic                                   prev_hit_o
);

  localparam logic [7:0] MAX_LEN = 8'(pPATTERN_BYTES);

  logic [pPATTERN_BYTES*BYTE_W-1:0] window;
  logic [7:0]                       len_c;
  logic                             bytes_ok;
  logic                             prev_q;

  always_comb begin
    window   = {history_i, cur_byte_i};
    len_c    = (length_i > MAX_LEN) ? MAX_LEN : length_i;
    bytes_ok = 1'b1;
    for (int i = 0; i < pPATTERN_BYTES; i++) begin
      if ((8'(i) < len_c) &&
          (((window[i*BYTE_W +: BYTE_W] ^ pattern_i[i*BYTE_W +: BYTE_W]) &
            mask_i[i*BYTE_W +: BYTE_W]) != '0)) begin
        bytes_ok = 1'b0;
      end
    end
    // Enough bytes must precede the current one to fill the pattern.
    hit_o = (len_c != 8'd0) && bytes_ok && (({1'b0, byte_count_i} + 9'd1) >= {1'b0, len_c});
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      prev_q <= 1'b0;
    end else if (step_i) begin
      prev_q <= hit_o;
    end
  end

  assign prev_hit_o = prev_q;

endmodule

// File: rtl/pattern_matcher_usb_multi.sv
// Multi-channel masked pattern matcher: history register, arm FSM, ANY/SEQ trigger
// logic and trigger counter with disarm pulse.
module pattern_matcher_usb_multi
  import pattern_matcher_usb_pkg::*;
#(
  parameter int pCHANNELS      = 4,
  parameter int pPATTERN_BYTES = 8,
  parameter int pCHW           = 3
) (
  input  logic                                         fe_clk,
  input  logic                                         reset_i,
  input  logic                                         I_arm,
  input  logic                                         I_mode,
  input  logic [pCHANNELS-1:0]                         I_chan_enable,
  input  logic [pCHW:0]                                I_seq_len,
  input  logic [15:0]                                  I_seq_timeout,
  input  logic [pCHANNELS*pPATTERN_BYTES*BYTE_W-1:0]   I_pattern,
  input  logic [pCHANNELS*pPATTERN_BYTES*BYTE_W-1:0]   I_mask,
  input  logic [pCHANNELS*8-1:0]                       I_pattern_bytes,
  input  logic [15:0]                                  I_num_triggers,
  input  logic [BYTE_W-1:0]                            I_fe_data,
  input  logic                                         I_fe_data_valid,
  input  logic                                         I_fe_sop,
  output logic                                         O_match_trigger,
  output logic [pCHW-1:0]                              O_match_channel,
  output logic [15:0]                                  O_num_triggers,
  output logic                                         O_disarm_pulse,
  output logic [pCHW-1:0]                              O_seq_stage
);

  localparam int            HW     = (pPATTERN_BYTES-1)*BYTE_W;
  localparam int            SLOT_W = pPATTERN_BYTES*BYTE_W;
  localparam logic [pCHW:0] CH_MAX = (pCHW+1)'(pCHANNELS);

  state_e                 state_q, state_d;
  logic                   arm_q, arm_rise, proc;
  logic [BYTE_W-1:0]      byte_q;
  logic                   valid_q, sop_q;
  logic [HW-1:0]          hist_q, hist_d;
  logic [7:0]             cnt_q, cnt_d, cnt_eff;
  logic [pCHW-1:0]        stage_q, stage_d, chan_q, chan_d, fire_chan;
  logic [15:0]            tmo_q, tmo_d, tmo_inc, fire_cnt_q, fire_cnt_d, num_q;
  logic                   trig_q, disarm_q, fire, adv, limit_hit;
  logic [pCHW:0]          seq_len_eff, seq_last;
  logic [pCHANNELS-1:0]   slot_hit, slot_prev, slot_evt;

  assign arm_rise = I_arm & ~arm_q;
  assign proc     = valid_q & I_arm & ~arm_rise & (state_q == ST_ARMED);
  // A start-of-packet byte sees an empty history, so matches never span packets.
  assign cnt_eff  = sop_q ? 8'd0 : cnt_q;
  assign slot_evt = slot_hit & ~slot_prev & {pCHANNELS{proc}};

  for (genvar c = 0; c < pCHANNELS; c++) begin : g_slot
    pattern_slot_compare #(.pPATTERN_BYTES(pPATTERN_BYTES)) u_cmp (
      .clk_i        (fe_clk),
      .reset_i      (reset_i),
      .clear_i      (arm_rise),
      .step_i       (proc),
      .history_i    (hist_q),
      .cur_byte_i   (byte_q),
      .pattern_i    (I_pattern[c*SLOT_W +: SLOT_W]),
      .mask_i       (I_mask[c*SLOT_W +: SLOT_W]),
      .length_i     (I_pattern_bytes[c*8 +: 8]),
      .byte_count_i (cnt_eff),
      .hit_o        (slot_hit[c]),
      .prev_hit_o   (slot_prev[c])
    );
  end

  always_comb begin
    seq_len_eff = (I_seq_len <= (pCHW+1)'(1)) ? (pCHW+1)'(1) :
                  ((I_seq_len > CH_MAX) ? CH_MAX : I_seq_len);
    seq_last    = seq_len_eff - (pCHW+1)'(1);
  end

  always_comb begin
    hist_d     = hist_q;
    cnt_d      = cnt_q;
    stage_d    = stage_q;
    tmo_d      = tmo_q;
    tmo_inc    = (tmo_q == 16'hFFFF) ? tmo_q : tmo_q + 16'd1;
    chan_d     = chan_q;
    fire_cnt_d = fire_cnt_q;
    fire       = 1'b0;
    fire_chan  = '0;
    adv        = 1'b0;
    limit_hit  = 1'b0;
    if (proc) begin
      hist_d[BYTE_W-1:0] = byte_q;
      for (int i = 1; i < pPATTERN_BYTES-1; i++) begin
        hist_d[i*BYTE_W +: BYTE_W] = hist_q[(i-1)*BYTE_W +: BYTE_W];
      end
      cnt_d = sop_q ? 8'd1 : ((cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1);
      if (I_mode == MODE_ANY) begin
        stage_d = '0;
        tmo_d   = '0;
        for (int c = pCHANNELS-1; c >= 0; c--) begin
          if (slot_evt[c] && I_chan_enable[c]) begin
            fire      = 1'b1;
            fire_chan = pCHW'(c);
          end
        end
      end else begin
        for (int c = 0; c < pCHANNELS; c++) begin
          if (stage_q == pCHW'(c)) adv = slot_evt[c];
        end
        // An advance on the same byte as a timeout takes priority.
        if (adv) begin
          tmo_d = '0;
          if ({1'b0, stage_q} == seq_last) begin
            fire      = 1'b1;
            fire_chan = stage_q;
            stage_d   = '0;
          end else begin
            stage_d = stage_q + pCHW'(1);
          end
        end else if (stage_q != '0) begin
          if ((I_seq_timeout != 16'd0) && (tmo_inc > I_seq_timeout)) begin
            stage_d = '0;
            tmo_d   = '0;
          end else begin
            tmo_d = tmo_inc;
          end
        end
      end
    end
    if (fire) begin
      chan_d     = fire_chan;
      fire_cnt_d = fire_cnt_q + 16'd1;
      limit_hit  = (I_num_triggers != 16'd0) && (I_num_triggers != NUM_TRIG_UNLIMITED) &&
                   (fire_cnt_d == I_num_triggers);
    end
  end

  always_comb begin
    state_d = state_q;
    if (!I_arm)         state_d = ST_IDLE;
    else if (arm_rise)  state_d = ST_ARMED;
    else if (limit_hit) state_d = ST_DONE;
  end

  always_ff @(posedge fe_clk) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      arm_q      <= 1'b0;
      byte_q     <= '0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      hist_q     <= '0;
      cnt_q      <= '0;
      stage_q    <= '0;
      tmo_q      <= '0;
      chan_q     <= '0;
      fire_cnt_q <= '0;
      num_q      <= '0;
      trig_q     <= 1'b0;
      disarm_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      arm_q    <= I_arm;
      byte_q   <= I_fe_data;
      valid_q  <= I_fe_data_valid & ~arm_rise;
      sop_q    <= I_fe_sop;
      chan_q   <= chan_d;
      trig_q   <= fire;
      disarm_q <= limit_hit;
      if (arm_rise) begin
        hist_q     <= '0;
        cnt_q      <= '0;
        stage_q    <= '0;
        tmo_q      <= '0;
        fire_cnt_q <= '0;
        num_q      <= '0;
      end else begin
        hist_q     <= hist_d;
        cnt_q      <= cnt_d;
        stage_q    <= stage_d;
        tmo_q      <= tmo_d;
        fire_cnt_q <= fire_cnt_d;
        num_q      <= fire_cnt_q;
      end
    end
  end

  assign O_match_trigger = trig_q;
  assign O_match_channel = chan_q;
  assign O_num_triggers  = num_q;
  assign O_disarm_pulse  = disarm_q;
  assign O_seq_stage     = stage_q;

endmodule

// File: tb/tb_pattern_matcher_usb_multi.sv
// Scoreboard bench for pattern_matcher_usb_multi: expected triggers are queued with
// their due cycle when the causing byte is driven and matched against DUT pulses.
module tb_pattern_matcher_usb_multi;
  import pattern_matcher_usb_pkg::*;

  localparam int CH  = 4;
  localparam int PB  = 8;
  localparam int CHW = 3;
  localparam int SW  = PB*8;
  localparam int EW  = 32 + 1 + CHW;

  logic                fe_clk = 1'b0;
  logic                reset_i;
  logic                I_arm, I_mode;
  logic [CH-1:0]       I_chan_enable;
  logic [CHW:0]        I_seq_len;
  logic [15:0]         I_seq_timeout;
  logic [CH*SW-1:0]    I_pattern, I_mask;
  logic [CH*8-1:0]     I_pattern_bytes;
  logic [15:0]         I_num_triggers;
  logic [7:0]          I_fe_data;
  logic                I_fe_data_valid, I_fe_sop;
  logic                O_match_trigger;
  logic [CHW-1:0]      O_match_channel;
  logic [15:0]         O_num_triggers;
  logic                O_disarm_pulse;
  logic [CHW-1:0]      O_seq_stage;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [EW-1:0] exp_q[$];

  pattern_matcher_usb_multi #(.pCHANNELS(CH), .pPATTERN_BYTES(PB), .pCHW(CHW)) dut (
    .fe_clk          (fe_clk),
    .reset_i         (reset_i),
    .I_arm           (I_arm),
    .I_mode          (I_mode),
    .I_chan_enable   (I_chan_enable),
    .I_seq_len       (I_seq_len),
    .I_seq_timeout   (I_seq_timeout),
    .I_pattern       (I_pattern),
    .I_mask          (I_mask),
    .I_pattern_bytes (I_pattern_bytes),
    .I_num_triggers  (I_num_triggers),
    .I_fe_data       (I_fe_data),
    .I_fe_data_valid (I_fe_data_valid),
    .I_fe_sop        (I_fe_sop),
    .O_match_trigger (O_match_trigger),
    .O_match_channel (O_match_channel),
    .O_num_triggers  (O_num_triggers),
    .O_disarm_pulse  (O_disarm_pulse),
    .O_seq_stage     (O_seq_stage)
  );

  // clock / cycle counter
  always #5 fe_clk = ~fe_clk;
  always @(posedge fe_clk) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge fe_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      I_fe_data_valid = 1'b0;
      I_fe_sop        = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic sop, input logic trig,
                      input logic [CHW-1:0] ch, input logic dis);
    tick();
    I_fe_data       = d;
    I_fe_data_valid = 1'b1;
    I_fe_sop        = sop;
    if (trig) exp_q.push_back({32'(cyc + 2), dis, ch});
  endtask

  task automatic rearm();
    tick();
    I_arm           = 1'b0;
    I_fe_data_valid = 1'b0;
    I_fe_sop        = 1'b0;
    idle(2);
    tick();
    I_arm = 1'b1;
  endtask

  task automatic set_slot(input int c, input logic [SW-1:0] pat, input logic [SW-1:0] msk,
                          input logic [7:0] len);
    I_pattern[c*SW +: SW]    = pat;
    I_mask[c*SW +: SW]       = msk;
    I_pattern_bytes[c*8 +: 8] = len;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_trigger"}, 32'(O_match_trigger), 32'd0);
    check({pfx, "_channel"}, 32'(O_match_channel), 32'd0);
    check({pfx, "_num"},     32'(O_num_triggers),  32'd0);
    check({pfx, "_disarm"},  32'(O_disarm_pulse),  32'd0);
    check({pfx, "_stage"},   32'(O_seq_stage),     32'd0);
  endtask

  // scoreboard
  always @(negedge fe_clk) begin
    logic [EW-1:0] e;
    if (!reset_i) begin
      if (O_match_trigger) begin
        if (exp_q.size() == 0) begin
          check("unexpected_trigger", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("trig_cycle",   32'(cyc),             e[EW-1:CHW+1]);
          check("trig_channel", 32'(O_match_channel), 32'(e[CHW-1:0]));
          check("trig_disarm",  32'(O_disarm_pulse),  32'(e[CHW]));
        end
      end else begin
        if (O_disarm_pulse) check("stray_disarm", 32'd1, 32'd0);
        while (exp_q.size() > 0 && exp_q[0][EW-1:CHW+1] < 32'(cyc)) begin
          e = exp_q.pop_front();
          check("missed_trigger", 32'd0, 32'd1);
        end
      end
    end
  end

  initial begin
    reset_i = 1'b1;  I_arm = 1'b0;  I_mode = MODE_ANY;  I_chan_enable = '1;
    I_seq_len = 2;   I_seq_timeout = 16'd4;
    I_pattern = '0;  I_mask = '0;   I_pattern_bytes = '0;
    I_num_triggers = NUM_TRIG_UNLIMITED;
    I_fe_data = 8'h00;  I_fe_data_valid = 1'b0;  I_fe_sop = 1'b0;

    repeat (3) tick();
    check_all_zero("reset");
    tick();
    reset_i = 1'b0;

    // ANY mode, ch2 = A5 5A
    set_slot(2, 64'hA55A, 64'hFFFF, 8'd2);
    rearm();
    send(8'h00, 1'b1, 1'b0, 3'd0, 1'b0);
    send(8'hA5, 1'b0, 1'b0, 3'd0, 1'b0);
    send(8'h5A, 1'b0, 1'b1, 3'd2, 1'b0);
    send(8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
    idle(4);
    check("any_num", 32'(O_num_triggers), 32'd1);
    check("any_chan_held", 32'(O_match_channel), 32'd2);

    // packet boundary blocks the match; same bytes inside one packet match
    send(8'hA5, 1'b1, 1'b0, 3'd0, 1'b0);
    send(8'h5A, 1'b1, 1'b0, 3'd0, 1'b0);
    send(8'hA5, 1'b1, 1'b0, 3'd0, 1'b0);
    send(8'h5A, 1'b0, 1'b1, 3'd2, 1'b0);
    idle(4);
    check("sop_num", 32'(O_num_triggers), 32'd2);

    // SEQ mode: ch0 = 80 then ch1 = 2D, timeout 4
    I_mode = MODE_SEQ;
    set_slot(0, 64'h80, 64'hFF, 8'd1);
    set_slot(1, 64'h2D, 64'hFF, 8'd1);
    set_slot(2, 64'h0, 64'h0, 8'd0);
    rearm();
    send(8'h80, 1'b1, 1'b0, 3'd0, 1'b0);
    send(8'h11, 1'b0, 1'b0, 3'd0, 1'b0);
    send(8'h22, 1'b0, 1'b0, 3'd0, 1'b0);
    send(8'h2D, 1'b0, 1'b1, 3'd1, 1'b0);
    idle(3);
    check("seq_stage_after_trig", 32'(O_seq_stage), 32'd0);
    send(8'h80, 1'b0, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 4; i++) send(8'(8'h11 * (i + 1)), 1'b0, 1'b0, 3'd0, 1'b0);
    idle(3);
    check("seq_stage_at_limit", 32'(O_seq_stage), 32'd1);
    send(8'h55, 1'b0, 1'b0, 3'd0, 1'b0);
    idle(3);
    check("seq_stage_timeout", 32'(O_seq_stage), 32'd0);
    send(8'h2D, 1'b0, 1'b0, 3'd0, 1'b0);
    idle(4);
    check("seq_num", 32'(O_num_triggers), 32'd1);

    // trigger limit of 3 with six events
    I_mode = MODE_ANY;
    I_chan_enable = 4'b0001;
    I_num_triggers = 16'd3;
    set_slot(1, 64'h0, 64'h0, 8'd0);
    rearm();
    for (int i = 0; i < 6; i++) begin
      send(8'h80, 1'b0, (i < 3), 3'd0, (i == 2));
      send(8'h11, 1'b0, 1'b0, 3'd0, 1'b0);
    end
    idle(4);
    check("limit_num", 32'(O_num_triggers), 32'd3);

    // run suppression with unlimited count
    I_num_triggers = NUM_TRIG_UNLIMITED;
    I_chan_enable = 4'b1000;
    set_slot(0, 64'h0, 64'h0, 8'd0);
    set_slot(3, 64'h00, 64'hFF, 8'd1);
    rearm();
    for (int i = 0; i < 10; i++) send(8'h00, 1'b0, (i == 0), 3'd3, 1'b0);
    send(8'h11, 1'b0, 1'b0, 3'd0, 1'b0);
    send(8'h00, 1'b0, 1'b1, 3'd3, 1'b0);
    idle(4);
    check("run_num", 32'(O_num_triggers), 32'd2);

    // arm edge coincident with a matching byte drops that byte
    tick();
    I_arm = 1'b0;
    I_fe_data_valid = 1'b0;
    idle(2);
    tick();
    I_arm = 1'b1;
    I_fe_data = 8'h00;
    I_fe_data_valid = 1'b1;
    I_fe_sop = 1'b0;
    send(8'h00, 1'b0, 1'b1, 3'd3, 1'b0);
    idle(4);
    check("armedge_num", 32'(O_num_triggers), 32'd1);

    // reset in the middle of a SEQ sequence
    I_mode = MODE_SEQ;
    set_slot(0, 64'h80, 64'hFF, 8'd1);
    send(8'h80, 1'b0, 1'b0, 3'd0, 1'b0);
    idle(3);
    check("mid_stage", 32'(O_seq_stage), 32'd1);
    tick();
    reset_i = 1'b1;
    tick();
    check_all_zero("midreset");
    tick();
    reset_i = 1'b0;
    I_arm = 1'b0;
    idle(4);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
